// File: rtl/filter_output_decimator.sv
// Decimate-by-2^DECIM_LOG2 averaging stage with rounding, output FIFO,
// sticky overflow flag and frame markers on the output stream.
module filter_output_decimator #(
  parameter int WORDLENGTH        = 14,
  parameter int FRACTIONAL_LENGTH = 6,
  parameter int DECIM_LOG2        = 2,
  parameter int FIFO_DEPTH        = 4,
  parameter int FRAME_LEN         = 8
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [WORDLENGTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic [WORDLENGTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  ovf,
  input  logic                  clr_ovf
);

  localparam int AW   = WORDLENGTH + DECIM_LOG2;
  localparam int NDEC = 1 << DECIM_LOG2;
  localparam int RND  = NDEC >> 1;
  localparam int PW   = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int FAW  = $clog2(FIFO_DEPTH);
  localparam int FW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  if (DECIM_LOG2 < 0 || DECIM_LOG2 > 4) begin : g_bad_decim
    $error("DECIM_LOG2 out of range");
  end
  if (FIFO_DEPTH < 2 || (1 << FAW) != FIFO_DEPTH) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  end
  if (FRAME_LEN < 1) begin : g_bad_frame
    $error("FRAME_LEN must be >= 1");
  end
  if (FRACTIONAL_LENGTH < 0 || FRACTIONAL_LENGTH >= WORDLENGTH) begin : g_bad_frac
    $error("FRACTIONAL_LENGTH out of range");
  end

  logic signed [AW-1:0] acc_q, acc_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic signed [AW:0]   sum_w;
  logic [WORDLENGTH-1:0] res_w;
  logic                 last_ph;
  logic                 res_v;

  assign last_ph = (phase_q == PW'(NDEC - 1));
  assign res_v   = s_tvalid && last_ph;

  // N samples plus the half-LSB term always fit in AW+1 bits
  assign sum_w = (AW+1)'(acc_q)
               + (AW+1)'($signed(s_tdata))
               + (AW+1)'(RND);
  assign res_w = WORDLENGTH'(sum_w >>> DECIM_LOG2);

  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    if (s_tvalid) begin
      if (last_ph) begin
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = acc_q + AW'($signed(s_tdata));
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      acc_q   <= '0;
      phase_q <= '0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
    end
  end

  logic [WORDLENGTH:0] mem_q [FIFO_DEPTH];
  logic [FAW-1:0]      wp_q, wp_d;
  logic [FAW-1:0]      rp_q, rp_d;
  logic [FAW:0]        cnt_q, cnt_d;
  logic [FW-1:0]       fr_q, fr_d;
  logic                ovf_q, ovf_d;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;
  logic                tl_w;

  assign full = (cnt_q == (FAW+1)'(FIFO_DEPTH));
  assign pop  = m_tvalid && m_tready;
  // a simultaneous pop frees the slot a full FIFO needs
  assign push = res_v && (!full || pop);
  assign drop = res_v && full && !pop;
  assign tl_w = (fr_q == FW'(FRAME_LEN - 1));

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    fr_d  = fr_q;
    ovf_d = ovf_q;
    if (push) begin
      wp_d = wp_q + 1'b1;
      fr_d = tl_w ? '0 : fr_q + 1'b1;
    end
    if (pop) begin
      rp_d = rp_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      fr_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      fr_q  <= fr_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q] <= {tl_w, res_w};
    end
  end

  // head is masked so an empty or freshly reset FIFO shows zero
  assign m_tvalid = (cnt_q != '0);
  assign m_tdata  = m_tvalid ? mem_q[rp_q][WORDLENGTH-1:0] : '0;
  assign m_tlast  = m_tvalid && mem_q[rp_q][WORDLENGTH];
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_filter_output_decimator.sv
// Randomized and directed bench for filter_output_decimator against a
// queue-based reference of the averaging, FIFO and framing rules.
module tb_filter_output_decimator;

  localparam int W  = 14;
  localparam int L  = 2;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int FL = 8;

  logic         clk = 1'b0;
  logic         arst_n;
  logic [W-1:0] s_tdata;
  logic         s_tvalid;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic         ovf;
  logic         clr_ovf;

  filter_output_decimator dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .ovf      (ovf),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } ent_t;

  int         total = 0;
  int         bad = 0;
  ent_t       mq[$];
  int         grp[$];
  int         fcnt;
  logic       movf;
  logic [W:0] outq[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    grp.delete();
    fcnt = 0;
    movf = 1'b0;
  endtask

  task automatic step(input logic v, input logic [W-1:0] d,
                      input logic r, input logic c);
    logic              pop;
    logic              have;
    logic              drop;
    logic signed [W-1:0] sd;
    int                s;
    ent_t              e;
    @(negedge clk);
    chk("vld", m_tvalid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("data", m_tdata, mq[0].d);
      chk("last", m_tlast, mq[0].l);
    end
    chk("ovf", ovf, movf);
    if (m_tvalid && r) outq.push_back({m_tlast, m_tdata});
    s_tvalid = v;
    s_tdata  = d;
    m_tready = r;
    clr_ovf  = c;
    pop  = (mq.size() > 0) && r;
    have = 1'b0;
    if (v) begin
      sd = d;
      grp.push_back(int'(sd));
      if (grp.size() == N) begin
        s = 0;
        foreach (grp[i]) s += grp[i];
        e.d  = W'((s + N / 2) >>> L);
        have = 1'b1;
        grp.delete();
      end
    end
    drop = have && (mq.size() == D) && !pop;
    if (pop) void'(mq.pop_front());
    if (have && !drop) begin
      e.l  = (fcnt == FL - 1);
      fcnt = (fcnt + 1) % FL;
      mq.push_back(e);
    end
    if (drop) movf = 1'b1;
    else if (c) movf = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    chk("rst_vld", m_tvalid, 1'b0);
    chk("rst_data", m_tdata, '0);
    chk("rst_last", m_tlast, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    s_tvalid = 1'b0;
    clr_ovf  = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    arst_n   = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    clr_ovf  = 1'b0;
    model_reset();
    #12;
    chk("init_vld", m_tvalid, 1'b0);
    chk("init_data", m_tdata, '0);
    chk("init_last", m_tlast, 1'b0);
    chk("init_ovf", ovf, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < 12; i++) step(1'b1, 14'h0040, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    step(1'b1, 14'h0001, 1'b0, 1'b0);
    step(1'b1, 14'h0001, 1'b0, 1'b0);
    step(1'b1, 14'h0001, 1'b0, 1'b0);
    step(1'b1, 14'h0000, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rnd_pos", m_tdata, 14'h0001);
    step(1'b0, '0, 1'b1, 1'b0);

    step(1'b1, 14'h3FFF, 1'b0, 1'b0);
    step(1'b1, 14'h3FFF, 1'b0, 1'b0);
    step(1'b1, 14'h3FFF, 1'b0, 1'b0);
    step(1'b1, 14'h3FFE, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rnd_neg", m_tdata, 14'h3FFF);
    step(1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) step(1'b1, 14'h1FFF, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rnd_max", m_tdata, 14'h1FFF);
    step(1'b0, '0, 1'b1, 1'b0);

    for (int i = 1; i <= 4; i++) begin
      step(1'b1, W'(4 * i), 1'b0, 1'b0);
      if (i < 4) step(1'b0, 14'h2AAA, 1'b0, 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    chk("gap", m_tdata, 14'h000A);
    step(1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) step(1'b1, 14'h0040, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("ovf_set", ovf, 1'b1);
    outq.delete();
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("drain_n", outq.size(), 4);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("ovf_clr", ovf, 1'b0);

    do_reset();
    outq.delete();
    for (int i = 0; i < 64; i++) step(1'b1, W'($urandom), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("frm_n", outq.size(), 16);
    for (int i = 0; i < outq.size(); i++)
      chk("frm_last", outq[i][W], (i == 7) || (i == 15));

    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 1) != 0,
           $urandom_range(0, 15) == 0);

    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 14'h0123, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 14'h0080, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("post_rst_vld", m_tvalid, 1'b1);
    chk("post_rst_data", m_tdata, 14'h0080);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_empty", m_tvalid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/filter_output_decimator.md
FILTER_OUTPUT_DECIMATOR -- requirements
Module: filter_output_decimator

Interface
REQ-001 The block SHALL have parameter WORDLENGTH, default 14: sample width in bits, signed two's complement.
REQ-002 The block SHALL have parameter FRACTIONAL_LENGTH, default 6: fractional bits (Q8.6), pass-through only, with no effect on the arithmetic.
REQ-003 The block SHALL have parameter DECIM_LOG2, default 2: decimation factor N = 2^DECIM_LOG2, legal range 0..4.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries, power of 2, at least 2.
REQ-005 The block SHALL have parameter FRAME_LEN, default 8: output words per frame, at least 1.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 arst_n  input  1  reset, asynchronous and active-low.
REQ-008 s_tdata  input  WORDLENGTH  signed filter output sample.
REQ-009 s_tvalid  input  1  s_tdata valid this cycle; no backpressure toward the source.
REQ-010 m_tdata  output  WORDLENGTH  signed decimated sample (FIFO head).
REQ-011 m_tvalid  output  1  FIFO non-empty.
REQ-012 m_tready  input  1  downstream accepts m_tdata.
REQ-013 m_tlast  output  1  m_tdata is the last word of a frame.
REQ-014 ovf  output  1  sticky flag: at least one result dropped because the FIFO was full.
REQ-015 clr_ovf  input  1  synchronous clear of ovf.

Function
REQ-016 The accumulator SHALL be signed, WORDLENGTH+DECIM_LOG2 bits wide, and never overflow.
REQ-017 The phase counter (0..N-1) SHALL advance and the accumulator SHALL add s_tdata only on cycles with s_tvalid=1; on cycles with s_tvalid=0 both SHALL hold.
REQ-018 On the Nth accepted sample, result SHALL = (acc + s_tdata + 2^(DECIM_LOG2-1)) >>> DECIM_LOG2 (round half toward +inf); the accumulator SHALL restart from 0 and the phase SHALL return to 0.
REQ-019 When DECIM_LOG2=0, every valid sample SHALL be a result with no rounding term.
REQ-020 The result SHALL always fit in WORDLENGTH bits; no saturation logic is needed.
REQ-021 The result SHALL be written into the FIFO on the same edge that accepts the Nth sample; if the FIFO was empty, m_tvalid=1 with that result from the next cycle (latency 1 clk).
REQ-022 A FIFO pop SHALL occur when m_tvalid && m_tready; m_tdata and m_tlast SHALL be stable while m_tvalid=1 and m_tready=0.
REQ-023 Output order SHALL be strictly first-in first-out.
REQ-024 FIFO full with a pop in the same cycle: the push SHALL succeed and occupancy SHALL be unchanged.
REQ-025 FIFO full with no pop: the result SHALL be dropped, ovf SHALL be set, and FIFO contents SHALL be unchanged.
REQ-026 Empty FIFO: a push SHALL occur and no pop SHALL occur; m_tvalid=0 that cycle.
REQ-027 clr_ovf=1 SHALL clear ovf on the next edge; a drop in the same cycle SHALL win, leaving ovf=1.
REQ-028 The frame counter (0..FRAME_LEN-1) SHALL advance on successful pushes only, so dropped results are not counted.
REQ-029 The pushed word SHALL carry tlast=1 when the frame counter is FRAME_LEN-1, after which the counter SHALL wrap to 0; tlast SHALL be stored in the FIFO alongside the data.

Reset
REQ-030 While arst_n=0, the block SHALL immediately, without waiting for clk, force: m_tvalid=0, m_tdata=0, m_tlast=0, ovf=0, accumulator=0, phase=0, frame counter=0, FIFO empty.
REQ-031 Reset asserted mid-accumulation or with the FIFO non-empty SHALL discard the partial sum and all queued words.
REQ-032 The first valid sample after deassertion SHALL be phase 0.

Verification
REQ-033 Defaults, s_tvalid=1, m_tready=1, constant s_tdata=0x0040 -> m_tdata=0x0040 with a one-cycle m_tvalid pulse every 4th cycle, 1 clk after each 4th sample.
REQ-034 Rounding: samples 0x0001,0x0001,0x0001,0x0000 -> 0x0001; samples 0x3FFF,0x3FFF,0x3FFF,0x3FFE (sum -5) -> 0x3FFF (-1); samples 0x1FFF x4 -> 0x1FFF.
REQ-035 Gapped input: s_tvalid toggling 1,0,1,0,... with samples 4,8,12,16 -> one result 0x000A after the 4th valid sample; the phase counter holds during gaps.
REQ-036 m_tready=0, 20 valid samples of 0x0040 -> 4 words queued, 5th result dropped, ovf=1; then m_tready=1 -> 4 words 0x0040 drain in order; clr_ovf pulse -> ovf=0.
REQ-037 FRAME_LEN=8, m_tready=1, 64 valid samples -> 16 outputs, m_tlast=1 exactly on outputs 8 and 16.
REQ-038 arst_n pulsed low after 2 of 4 samples with 2 words queued -> m_tvalid=0 immediately; next 4 samples of 0x0080 -> a single 0x0080, with no contribution from the pre-reset samples.
